// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation searcher.
package sar_pkg;

   localparam int unsigned WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      DONE
   } state_t;

endpackage

// File: rtl/sar_searcher.sv
// Binary search of a target through an external comparator (GT/EQ/LT).
// Optional COMPARE-cycle counter output cmp_cnt when SAR_SEARCHER_CNT_EN is defined.
module sar_searcher
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             GT,
   input  logic             EQ,
   input  logic             LT,
   output logic [WIDTH-1:0] guess,
   output logic             En,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
`ifdef SAR_SEARCHER_CNT_EN
   output logic [$clog2(WIDTH+2)-1:0] cmp_cnt,
`endif
   output logic             found,
   output logic             err
);

   localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};

   state_t state, next_state;

   // Bounds carry one extra bit so lo can pass hi without wrapping.
   logic [WIDTH:0] lo, hi;
   logic [WIDTH:0] span, mid, lo_inc, hi_dec;
   logic           hi_under;

   logic ld_start, hit, step_lo, step_hi, bad;

   always_comb begin
      span     = hi - lo;
      mid      = lo + (span >> 1);
      lo_inc   = mid + 1'b1;
      hi_dec   = mid - 1'b1;
      hi_under = (mid == '0);
   end

   assign guess = (state == COMPARE) ? mid[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      ld_start   = 1'b0;
      hit        = 1'b0;
      step_lo    = 1'b0;
      step_hi    = 1'b0;
      bad        = 1'b0;
      En         = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               ld_start   = 1'b1;
               next_state = COMPARE;
            end
         end
         COMPARE: begin
            En   = 1'b1;
            busy = 1'b1;
            case ({GT, EQ, LT})
               3'b010: begin
                  hit        = 1'b1;
                  next_state = DONE;
               end
               3'b001: begin
                  step_lo = 1'b1;
                  if (lo_inc > hi) next_state = DONE;
               end
               3'b100: begin
                  // guess==0 would wrap hi to -1: treat as an empty range.
                  step_hi = 1'b1;
                  if (hi_under || (lo > hi_dec)) next_state = DONE;
               end
               default: begin
                  bad        = 1'b1;
                  next_state = DONE;
               end
            endcase
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo     <= '0;
         hi     <= '0;
         result <= '0;
         found  <= 1'b0;
         err    <= 1'b0;
      end else if (ld_start) begin
         lo    <= '0;
         hi    <= HI_INIT;
         found <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (hit) begin
            result <= mid[WIDTH-1:0];
            found  <= 1'b1;
         end
         if (step_lo) lo <= lo_inc;
         if (step_hi) hi <= hi_dec;
         if (bad) begin
            err   <= 1'b1;
            found <= 1'b0;
         end
      end
   end

`ifdef SAR_SEARCHER_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cmp_cnt <= '0;
      else if (ld_start)          cmp_cnt <= '0;
      else if (state == COMPARE)  cmp_cnt <= cmp_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_sar_searcher.sv
// Self-checking bench for sar_searcher: directed table, reset corner case, random targets.
module tb_sar_searcher;
   import sar_pkg::*;

   localparam int unsigned W   = 4;
   localparam int          TOP = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n, start, GT, EQ, LT;
   logic [W-1:0] guess, result;
   logic         En, busy, done, found, err;
`ifdef SAR_SEARCHER_CNT_EN
   logic [$clog2(W+2)-1:0] cmp_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int target   = 0;
   int mode     = 0;  // 0: honest comparator, 1: GT and LT both high, 2: always GT
   int seen[$];

   sar_searcher #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .GT     (GT),
      .EQ     (EQ),
      .LT     (LT),
      .guess  (guess),
      .En     (En),
      .busy   (busy),
      .done   (done),
      .result (result),
`ifdef SAR_SEARCHER_CNT_EN
      .cmp_cnt(cmp_cnt),
`endif
      .found  (found),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Comparator with B input tied to the target.
   always_comb begin
      GT = 1'b0;
      EQ = 1'b0;
      LT = 1'b0;
      case (mode)
         1: begin GT = 1'b1; LT = 1'b1; end
         2: GT = 1'b1;
         default: begin
            GT = int'(guess) > target;
            EQ = int'(guess) == target;
            LT = int'(guess) < target;
         end
      endcase
   end

   typedef struct {
      int n;
      int g[8];
      bit found;
      bit err;
   } outcome_t;

   typedef struct {
      int       tgt;
      int       md;
      outcome_t exp;
   } vec_t;

   function automatic outcome_t model(int tgt, int md);
      outcome_t o;
      int lo = 0;
      int hi = TOP;
      int g;
      o.n = 0;
      o.found = 1'b0;
      o.err = 1'b0;
      for (int i = 0; i < 8; i++) o.g[i] = 0;
      while (lo <= hi && o.n < 8) begin
         g = (lo + hi) / 2;
         o.g[o.n] = g;
         o.n++;
         if (md == 1) begin
            o.err = 1'b1;
            break;
         end
         if (md == 2 || g > tgt) hi = g - 1;
         else if (g < tgt)       lo = g + 1;
         else begin
            o.found = 1'b1;
            break;
         end
      end
      return o;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " guess"},  int'(guess),  0);
      check({tag, " En"},     int'(En),     0);
      check({tag, " busy"},   int'(busy),   0);
      check({tag, " done"},   int'(done),   0);
      check({tag, " result"}, int'(result), 0);
      check({tag, " found"},  int'(found),  0);
      check({tag, " err"},    int'(err),    0);
`ifdef SAR_SEARCHER_CNT_EN
      check({tag, " cmp_cnt"}, int'(cmp_cnt), 0);
`endif
   endtask

   // Starts a search and logs guesses until En drops; returns at the negedge after the last compare.
   task automatic run(input int tgt, input int md);
      int budget;
      target = tgt;
      mode   = md;
      seen.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      budget = 0;
      while (En && budget < 20) begin
         seen.push_back(int'(guess));
         @(negedge clk);
         budget++;
      end
   endtask

   task automatic verify(input string tag, input outcome_t e);
      int act;
      bit f0, e0;
      int r0;
      check({tag, " done after last compare"}, int'(done), 1);
      check({tag, " compares"}, seen.size(), e.n);
      for (int i = 0; i < e.n; i++) begin
         act = (i < seen.size()) ? seen[i] : -1;
         check($sformatf("%s guess%0d", tag, i), act, e.g[i]);
      end
      check({tag, " found"}, int'(found), int'(e.found));
      check({tag, " err"},   int'(err),   int'(e.err));
      if (e.found) check({tag, " result"}, int'(result), target);
      check({tag, " busy in done"}, int'(busy), 1);
      check({tag, " guess in done"}, int'(guess), 0);
`ifdef SAR_SEARCHER_CNT_EN
      check({tag, " cmp_cnt"}, int'(cmp_cnt), e.n);
`endif
      f0 = found;
      e0 = err;
      r0 = int'(result);
      start = 1'b1;  // lands in the DONE cycle and must be ignored
      @(negedge clk);
      start = 1'b0;
      check({tag, " done pulse width"}, int'(done), 0);
      @(negedge clk);
      check({tag, " start in done ignored"}, int'(busy), 0);
      check({tag, " found held"}, int'(found), int'(f0));
      check({tag, " err held"},   int'(err),   int'(e0));
      check({tag, " result held"}, int'(result), r0);
`ifdef SAR_SEARCHER_CNT_EN
      check({tag, " cmp_cnt held"}, int'(cmp_cnt), e.n);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[5];
      outcome_t m;
      bit saw_done;

      vecs[0] = '{tgt: 9,  md: 0, exp: '{n: 3, g: '{7, 11, 9, 0, 0, 0, 0, 0},   found: 1'b1, err: 1'b0}};
      vecs[1] = '{tgt: 0,  md: 0, exp: '{n: 4, g: '{7, 3, 1, 0, 0, 0, 0, 0},    found: 1'b1, err: 1'b0}};
      vecs[2] = '{tgt: 15, md: 0, exp: '{n: 5, g: '{7, 11, 13, 14, 15, 0, 0, 0}, found: 1'b1, err: 1'b0}};
      vecs[3] = '{tgt: 5,  md: 1, exp: '{n: 1, g: '{7, 0, 0, 0, 0, 0, 0, 0},    found: 1'b0, err: 1'b1}};
      vecs[4] = '{tgt: 15, md: 2, exp: '{n: 4, g: '{7, 3, 1, 0, 0, 0, 0, 0},    found: 1'b0, err: 1'b0}};

      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check_idle_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle without start", int'(busy), 0);

      for (int i = 0; i < 5; i++) begin
         run(vecs[i].tgt, vecs[i].md);
         verify($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Start while busy is ignored; reset after the second compare abandons the search.
      target = 9;
      mode   = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check("rst seq guess0", int'(guess), 7);
      @(negedge clk);
      start = 1'b0;
      check("rst seq guess1 after busy start", int'(guess), 11);
      @(negedge clk);
      check("rst seq guess2", int'(guess), 9);
      rst_n = 1'b0;
      #1;
      check_idle_zero("mid-search reset");
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("no done after reset", int'(saw_done), 0);
      check("waits for start after reset", int'(busy), 0);
      run(9, 0);
      verify("after reset", vecs[0].exp);

      for (int k = 0; k < 30; k++) begin
         int t, md;
         t  = int'($urandom_range(0, TOP));
         md = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
         m  = model(t, md);
         run(t, md);
         verify($sformatf("rand%0d t=%0d m=%0d", k, t, md), m);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sar_searcher.md
SAR_SEARCHER -- requirements
Module: sar_searcher

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the bit width of the searched value and of the guess bus.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, a one-cycle request to begin a search; it is honoured only in IDLE.
REQ-005 SHALL have ports GT, EQ and LT, each an input of 1 bit, giving the external comparator result for guess against the target (GT: guess > target).
REQ-006 SHALL have port guess, output, WIDTH bits, the value driven to the comparator A input.
REQ-007 SHALL have port En, output, 1 bit, the comparator enable; it is high only in COMPARE.
REQ-008 SHALL have port busy, output, 1 bit, high in COMPARE and DONE.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle pulse on search completion.
REQ-010 SHALL have port result, output, WIDTH bits, the value found; it is valid when found=1.
REQ-011 SHALL have ports found and err, each an output of 1 bit, giving the completion status.

Function
REQ-012 SHALL implement FSM states IDLE, COMPARE and DONE.
REQ-013 SHALL, in IDLE with start=1, load lo=0 and hi=2^WIDTH-1 and clear found and err, then enter COMPARE on the next edge.
REQ-014 SHALL, in COMPARE, drive guess = lo + ((hi-lo)>>1) combinationally from the registers, with arithmetic in WIDTH+1 bits, and assert En=1.
REQ-015 SHALL sample GT, EQ and LT at the COMPARE clock edge, under the same-cycle combinational comparator timing contract.
REQ-016 SHALL, on EQ only: set result=guess and found=1, then enter DONE.
REQ-017 SHALL, on LT only: set lo=guess+1; if the new lo>hi, set found=0 and enter DONE; otherwise stay in COMPARE.
REQ-018 SHALL, on GT only: set hi=guess-1, with underflow to -1 in WIDTH+1 bits treated as lo>hi; if lo>hi, set found=0 and enter DONE; otherwise stay in COMPARE.
REQ-019 SHALL, when not exactly one of GT, EQ and LT is high: set err=1 and found=0, then enter DONE.
REQ-020 SHALL, in DONE: pulse done=1 for one cycle and return to IDLE.
REQ-021 SHALL hold result, found and err stable from DONE until the next accepted start.
REQ-022 SHALL ignore start outside IDLE, including start asserted while busy and start in the DONE cycle.
REQ-023 SHALL complete a search with a consistent comparator in at most WIDTH+1 COMPARE cycles.
REQ-024 SHALL drive guess=0 and En=0 outside COMPARE.

Reset
REQ-025 SHALL, on rst_n low: enter IDLE immediately with guess=0, En=0, busy=0, done=0, result=0, found=0, err=0, lo=0 and hi=0.
REQ-026 SHALL, on reset mid-search, abandon the search with no done pulse; after release, the block waits for a new start.

Configuration
REQ-027 SHALL, with macro SAR_SEARCHER_CNT_EN defined, add an output cmp_cnt of $clog2(WIDTH+2) bits counting COMPARE cycles.
REQ-028 SHALL clear cmp_cnt on an accepted start and reset it to 0.
REQ-029 SHALL hold cmp_cnt through DONE until the next start.
REQ-030 SHALL, without SAR_SEARCHER_CNT_EN, omit the cmp_cnt port and its counter, with all other behaviour identical.

Structure
REQ-031 SHALL place the state enum (IDLE, COMPARE, DONE) and the default WIDTH constant in shared package sar_pkg.
REQ-032 SHALL be a single module with no sub-modules; the comparator is instantiated only in the testbench, driving its B input with the target.

Verification
REQ-033 SHALL cover target 9, WIDTH=4: the guess sequence is 7(LT), 11(GT), 9(EQ); done occurs in the cycle after the third compare, with result=9, found=1, err=0 and cmp_cnt=3.
REQ-034 SHALL cover target 0: the guess sequence is 7, 3, 1, 0; the search ends with found=1, result=0 and cmp_cnt=4.
REQ-035 SHALL cover target 15: the guess sequence is 7, 11, 13, 14, 15; the search ends with found=1, result=15 and cmp_cnt=5, which is the WIDTH+1 bound.
REQ-036 SHALL cover forced GT=1 and LT=1 in the first compare: done follows with err=1 and found=0.
REQ-037 SHALL cover a forced GT on every compare: guesses 7, 3, 1, 0, then hi underflow gives done with found=0 and err=0.
REQ-038 SHALL cover start pulsed during COMPARE (ignored) and rst_n low after the second compare: the block returns to IDLE immediately with all outputs 0 and no done pulse; a fresh start with target 9 then reproduces the first scenario.
